// File: rtl/bus_arbiter.sv
// bus_arbiter: arbitrates the instruction-fetch and data ports onto one memory bus with timeout.
module bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_stallreq_o,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_stallreq_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        bus_err_o
);
  typedef enum logic [2:0] {IDLE, IF_BUSY, MEM_BUSY, IF_DONE, MEM_DONE} state_t;
  state_t      state;
  logic        last_mem;
  logic [15:0] cnt;
  logic        is_mem, owner_ce, tmo, grant_mem;
  logic [31:0] cap_data;
  assign is_mem    = state == MEM_BUSY;
  assign owner_ce  = is_mem ? mem_ce_i : if_ce_i;
  assign tmo       = cnt == 16'(TIMEOUT_CYCLES - 1);
  // with both ports requesting, the data port wins unless it was served last
  assign grant_mem = mem_ce_i && (!if_ce_i || !last_mem);
  assign cap_data  = (bus_ack_i && !bus_we_o) ? bus_rdata_i : 32'd0;
  assign if_stallreq_o  = if_ce_i && state != IF_DONE;
  assign mem_stallreq_o = mem_ce_i && state != MEM_DONE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      last_mem    <= 1'b0;
      cnt         <= '0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_err_o   <= 1'b0;
      bus_sel_o   <= '0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      if_data_o   <= '0;
      mem_data_o  <= '0;
    end else begin
      case (state)
        IDLE: if (mem_ce_i || if_ce_i) begin
          state       <= grant_mem ? MEM_BUSY : IF_BUSY;
          bus_req_o   <= 1'b1;
          bus_we_o    <= grant_mem && mem_we_i;
          bus_sel_o   <= grant_mem ? mem_sel_i : 4'b1111;
          bus_addr_o  <= grant_mem ? mem_addr_i : if_addr_i;
          bus_wdata_o <= grant_mem ? mem_data_i : 32'd0;
          cnt         <= '0;
        end
        IF_BUSY, MEM_BUSY: if (bus_ack_i || tmo) begin
          bus_req_o <= 1'b0;
          last_mem  <= is_mem;
          if (!bus_ack_i) bus_err_o <= 1'b1;
          // a flushed requester gets no DONE cycle and no data update
          if (owner_ce) begin
            state <= is_mem ? MEM_DONE : IF_DONE;
            if (is_mem) mem_data_o <= cap_data;
            else if_data_o <= cap_data;
          end else begin
            state <= IDLE;
          end
        end else begin
          cnt <= cnt + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed vectors with hand-computed expectations for bus_arbiter.
module tb_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_ce_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_stallreq_o;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        mem_stallreq_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;
  logic        bus_err_o;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_stallreq_o(if_stallreq_o),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i), .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i), .mem_data_o(mem_data_o), .mem_stallreq_o(mem_stallreq_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i), .bus_err_o(bus_err_o)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
  endtask
  task automatic bus_chk(input string tag, input logic req, input logic we, input logic [3:0] sel,
                         input logic [31:0] addr, input logic [31:0] wdata);
    chk({tag, "_req"}, 32'(bus_req_o), 32'(req));
    chk({tag, "_we"}, 32'(bus_we_o), 32'(we));
    chk({tag, "_sel"}, 32'(bus_sel_o), 32'(sel));
    chk({tag, "_addr"}, bus_addr_o, addr);
    chk({tag, "_wdata"}, bus_wdata_o, wdata);
  endtask
  initial begin
    rst = 1'b0; if_ce_i = 0; if_addr_i = 0; mem_ce_i = 0; mem_we_i = 0; mem_sel_i = 0;
    mem_addr_i = 0; mem_data_i = 0; bus_ack_i = 0; bus_rdata_i = 0;
    cyc(); cyc();
    bus_chk("rst", 0, 0, 4'h0, 0, 0);
    chk("rst_err", 32'(bus_err_o), 0);
    chk("rst_ifd", if_data_o, 0);
    chk("rst_memd", mem_data_o, 0);
    rst = 1'b1;
    cyc();
    // fetch only, minimum latency
    if_ce_i = 1; if_addr_i = 32'h100; #1;
    chk("f_stall0", 32'(if_stallreq_o), 1);
    cyc();
    bus_chk("f_busy", 1, 0, 4'hf, 32'h100, 0);
    bus_ack_i = 1; bus_rdata_i = 32'h00500093;
    cyc();
    chk("f_data", if_data_o, 32'h00500093);
    chk("f_stall2", 32'(if_stallreq_o), 0);
    chk("f_req2", 32'(bus_req_o), 0);
    if_ce_i = 0; bus_ack_i = 0;
    cyc();
    // simultaneous requests: MEM first, then IF by alternation
    if_ce_i = 1; if_addr_i = 32'h104; mem_ce_i = 1; mem_we_i = 0; mem_sel_i = 4'hf; mem_addr_i = 32'h200;
    cyc();
    bus_chk("s_mem", 1, 0, 4'hf, 32'h200, 0);
    chk("s_ifst1", 32'(if_stallreq_o), 1);
    bus_ack_i = 1; bus_rdata_i = 32'h11112222;
    cyc();
    chk("s_memd", mem_data_o, 32'h11112222);
    chk("s_memst", 32'(mem_stallreq_o), 0);
    chk("s_ifst2", 32'(if_stallreq_o), 1);
    bus_ack_i = 0;
    cyc();
    chk("s_nogrant", 32'(bus_req_o), 0);
    chk("s_ifst3", 32'(if_stallreq_o), 1);
    cyc();
    bus_chk("s_if", 1, 0, 4'hf, 32'h104, 0);
    chk("s_ifst4", 32'(if_stallreq_o), 1);
    bus_ack_i = 1; bus_rdata_i = 32'h33334444;
    cyc();
    chk("s_ifd", if_data_o, 32'h33334444);
    chk("s_ifst5", 32'(if_stallreq_o), 0);
    chk("s_memhold", mem_data_o, 32'h11112222);
    if_ce_i = 0; mem_ce_i = 0; bus_ack_i = 0;
    cyc();
    // store, two busy cycles, rdata must be ignored
    mem_ce_i = 1; mem_we_i = 1; mem_sel_i = 4'b0011; mem_addr_i = 32'h40; mem_data_i = 32'hDEADBEEF;
    cyc();
    bus_chk("st_b1", 1, 1, 4'b0011, 32'h40, 32'hDEADBEEF);
    cyc();
    bus_chk("st_b2", 1, 1, 4'b0011, 32'h40, 32'hDEADBEEF);
    bus_ack_i = 1; bus_rdata_i = 32'hFFFFFFFF;
    cyc();
    chk("st_memd", mem_data_o, 0);
    chk("st_req", 32'(bus_req_o), 0);
    chk("st_stall", 32'(mem_stallreq_o), 0);
    mem_ce_i = 0; mem_we_i = 0; bus_ack_i = 0;
    cyc();
    // plain load
    mem_ce_i = 1; mem_sel_i = 4'hf; mem_addr_i = 32'h20;
    cyc();
    bus_ack_i = 1; bus_rdata_i = 32'h5A5A5A5A;
    cyc();
    chk("ld_memd", mem_data_o, 32'h5A5A5A5A);
    mem_ce_i = 0; bus_ack_i = 0;
    cyc();
    // timeout after 4 busy cycles
    mem_ce_i = 1; mem_addr_i = 32'h300;
    cyc();
    chk("to_req1", 32'(bus_req_o), 1);
    cyc(); cyc(); cyc();
    chk("to_req4", 32'(bus_req_o), 1);
    chk("to_err4", 32'(bus_err_o), 0);
    chk("to_hold", mem_data_o, 32'h5A5A5A5A);
    cyc();
    chk("to_req5", 32'(bus_req_o), 0);
    chk("to_err5", 32'(bus_err_o), 1);
    chk("to_memd", mem_data_o, 0);
    chk("to_stall", 32'(mem_stallreq_o), 0);
    mem_ce_i = 0;
    cyc();
    chk("to_sticky", 32'(bus_err_o), 1);
    // flush during IF_BUSY
    if_ce_i = 1; if_addr_i = 32'h108;
    cyc();
    bus_chk("fl_busy", 1, 0, 4'hf, 32'h108, 0);
    if_ce_i = 0;
    cyc();
    bus_ack_i = 1; bus_rdata_i = 32'hAAAA5555;
    cyc();
    chk("fl_req", 32'(bus_req_o), 0);
    chk("fl_ifd", if_data_o, 32'h33334444);
    cyc();
    chk("fl_ign_req", 32'(bus_req_o), 0);
    chk("fl_ifd2", if_data_o, 32'h33334444);
    chk("fl_err", 32'(bus_err_o), 1);
    bus_ack_i = 0;
    cyc();
    // asynchronous reset during MEM_BUSY
    mem_ce_i = 1; mem_we_i = 1; mem_sel_i = 4'hf; mem_addr_i = 32'h44; mem_data_i = 32'h12345678;
    cyc();
    bus_chk("r_busy", 1, 1, 4'hf, 32'h44, 32'h12345678);
    #2 rst = 1'b0;
    #1;
    bus_chk("r_async", 0, 0, 4'h0, 0, 0);
    chk("r_err", 32'(bus_err_o), 0);
    chk("r_ifd", if_data_o, 0);
    chk("r_memd", mem_data_o, 0);
    cyc();
    mem_ce_i = 0; rst = 1'b1; bus_ack_i = 1; bus_rdata_i = 32'hCAFEF00D;
    cyc(); cyc();
    chk("r_late_req", 32'(bus_req_o), 0);
    chk("r_late_memd", mem_data_o, 0);
    chk("r_late_err", 32'(bus_err_o), 0);
    bus_ack_i = 0;
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
